// File: rtl/pipe_pkg.sv
// Shared types for the flow-controlled pipeline stage: state encoding and occupancy.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pstate_t;

  localparam logic [1:0] OCC_NONE = 2'd0;
  localparam logic [1:0] OCC_ONE  = 2'd1;
  localparam logic [1:0] OCC_TWO  = 2'd2;

  function automatic logic [1:0] occ_of(input pstate_t s);
    case (s)
      FULL:    return OCC_ONE;
      SKID:    return OCC_TWO;
      default: return OCC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter with synchronous clear taking priority over increment.
module pipe_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                   cnt_d = '0;
    else if (inc && ~&cnt_q)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid so in_ready comes straight from a flop;
// en freezes the stage, flush empties it, and two saturating counters track stalls/bubbles.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W         = 128,
  parameter int CNT_W          = 16,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pstate_t           state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept, drain;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != SKID);
  assign out_data  = main_q;
  assign occ       = occ_of(state_q);

  assign accept = en & in_valid & in_ready;
  assign drain  = en & out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    // Flush overrides everything, including a frozen stage.
    if (flush) begin
      state_d = EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d = FULL;
          main_d  = in_data;
        end
        FULL: begin
          if (accept && drain) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = SKID;
            skid_d  = in_data;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        SKID: if (drain) begin
          state_d = FULL;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (en & out_valid & ~out_ready),
    .clr  (cnt_clr),
    .cnt  (stall_cnt)
  );

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (en & ~out_valid),
    .clr  (cnt_clr),
    .cnt  (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised scoreboard bench for pipe_stage_skid: a FIFO-queue reference model plus
// saturating counter models, checked every cycle just before the rising edge.
module tb_pipe_stage_skid;

  localparam int DW  = 32;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          en = 1'b0, flush = 1'b0, cnt_clr = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occ;
  logic [CW-1:0] stall_cnt, bubble_cnt;

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(CW), .CLEAR_ON_FLUSH(1'b1)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .en         (en),
    .flush      (flush),
    .cnt_clr    (cnt_clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occ        (occ),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  always #5 CLK = ~CLK;

  int n_tot  = 0;
  int n_pass = 0;

  // Reference model: entries held, in arrival order.
  logic [DW-1:0] exp_q[$];
  int            stall_m = 0;
  int            bub_m   = 0;
  bit            zero_exp = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: compares DUT state against the model, then advances the model by one edge.
  initial begin
    int  occ_m;
    bit  acc, drn;
    forever begin
      @(negedge CLK);
      #4;
      if (!nRST) begin
        exp_q.delete();
        stall_m  = 0;
        bub_m    = 0;
        zero_exp = 1'b1;
      end else begin
        occ_m = exp_q.size();
        chk("occ",        64'(occ),        64'(occ_m));
        chk("out_valid",  64'(out_valid),  64'(occ_m > 0));
        chk("in_ready",   64'(in_ready),   64'(occ_m < 2));
        chk("stall_cnt",  64'(stall_cnt),  64'(stall_m));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(bub_m));
        if (occ_m > 0)     chk("out_data", 64'(out_data), 64'(exp_q[0]));
        else if (zero_exp) chk("out_data_zero", 64'(out_data), 64'd0);

        acc = en && in_valid && (occ_m < 2);
        drn = en && out_ready && (occ_m > 0);

        if (cnt_clr) begin
          stall_m = 0;
          bub_m   = 0;
        end else begin
          if (en && occ_m > 0 && !out_ready && stall_m < CMAX) stall_m++;
          if (en && occ_m == 0 && bub_m < CMAX)                bub_m++;
        end

        if (flush) begin
          exp_q.delete();
          zero_exp = 1'b1;
        end else begin
          if (drn) void'(exp_q.pop_front());
          if (acc) begin
            exp_q.push_back(in_data);
            zero_exp = 1'b0;
          end
        end
      end
    end
  end

  task automatic cyc(input bit e, input bit iv, input logic [DW-1:0] d,
                     input bit ordy, input bit fl = 1'b0, input bit clr = 1'b0);
    @(negedge CLK);
    en        = e;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    cnt_clr   = clr;
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    #1 nRST = 1'b1;

    // Single entry then a back-to-back stream.
    cyc(1, 1, 32'hA5, 1);
    for (int i = 1; i <= 16; i++) cyc(1, 1, DW'(i), 1);
    repeat (3) cyc(1, 0, '0, 1);

    // Skid fill and drain.
    cyc(1, 1, 32'h11, 0);
    cyc(1, 1, 32'h22, 0);
    cyc(1, 1, 32'h99, 0);
    cyc(1, 0, '0, 1);
    cyc(1, 0, '0, 1);
    cyc(1, 0, '0, 1);

    // Freeze in SKID, then flush while frozen with a live input.
    cyc(1, 1, 32'h33, 0);
    cyc(1, 1, 32'h44, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, $urandom, 1);
    cyc(0, 1, 32'h55, 0, 1);
    cyc(0, 0, '0, 0);

    // Stall saturation, clear, then bubbles.
    cyc(1, 1, 32'h66, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, '0, 0);
    cyc(0, 0, '0, 0, 1, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, '0, 1);
    cyc(0, 0, '0, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0, $urandom,
          $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0,
          $urandom_range(0, 60) == 0);

    // Asynchronous reset while two entries are held.
    cyc(0, 0, '0, 0, 1);
    cyc(1, 1, 32'h77, 0);
    cyc(1, 1, 32'h88, 0);
    cyc(0, 0, '0, 0);
    #2 nRST = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_occ",       64'(occ),       64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_stall",     64'(stall_cnt), 64'd0);
    chk("rst_bubble",    64'(bubble_cnt),64'd0);
    @(negedge CLK);
    #1 nRST = 1'b1;
    repeat (3) cyc(1, 1, $urandom, 1);
    repeat (3) cyc(1, 0, '0, 1);

    @(negedge CLK);
    #6;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, flow-controlled pipeline stage register. It is the successor to the fixed-field, enable-gated stage latches between CPU stages.
- Carries an opaque payload of DATA_W bits, with valid/ready handshakes on both sides.
- A 2-entry skid buffer keeps in_ready registered. A global advance enable (en, driven from ihit|dhit) freezes the stage.
- Adds flush (bubble insertion), occupancy state and saturating stall/bubble performance counters.

Parameters:
- DATA_W, 128, payload width in bits (packed stage fields).
- CNT_W, 16, width of each performance counter.
- CLEAR_ON_FLUSH, 1, when 1, flush also zeroes both payload registers.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- en  input  1  global advance; when 0, no state, data or counter changes except flush and cnt_clr.
- flush  input  1  kill all held entries.
- cnt_clr  input  1  synchronous clear of both counters.
- in_valid  input  1  upstream has payload.
- in_ready  output  1  stage can accept; decoded from state register only.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  out_data holds a live entry.
- out_ready  input  1  downstream consumes.
- out_data  output  DATA_W  head entry (main register).
- occ  output  2  entries held (0, 1 or 2).
- stall_cnt  output  CNT_W  cycles with en & out_valid & !out_ready.
- bubble_cnt  output  CNT_W  cycles with en & !out_valid.

Behaviour:
- Reset (nRST=0, asynchronous):
  - state=EMPTY; main and skid registers = 0; counters = 0.
  - Resulting outputs: out_valid=0, in_ready=1, occ=0, out_data=0.
  - Reset mid-transfer discards all entries.
- Handshake definitions:
  - accept = en & in_valid & in_ready.
  - drain = en & out_valid & out_ready.
- States: EMPTY (occ 0), FULL (occ 1, main live), SKID (occ 2, main+skid live).
- Outputs by state:
  - out_valid = (state != EMPTY).
  - in_ready = (state != SKID); no combinational path from out_ready.
  - out_data = main.
- Transitions, evaluated on rising CLK:
  - EMPTY: accept -> FULL, main<=in_data.
  - FULL:
    - accept & drain -> FULL, main<=in_data.
    - accept & !drain -> SKID, skid<=in_data.
    - !accept & drain -> EMPTY.
    - otherwise hold.
  - SKID: drain -> FULL, main<=skid. No accept is possible in SKID.
- Latency and order:
  - 1 cycle from accept to out_valid when empty; throughput 1 entry/cycle sustained.
  - FIFO order is preserved.
- en=0:
  - Full freeze; accept and drain are both 0 regardless of valid/ready.
  - Counters do not count.
- Flush:
  - Dominates all other events and acts even when en=0.
  - Next state EMPTY, occ=0. Any accept or drain in the same cycle is void: input dropped, output not counted as consumed.
  - CLEAR_ON_FLUSH=1: main and skid <= 0. CLEAR_ON_FLUSH=0: payload registers hold.
- Counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - cnt_clr has priority over increment, so a cleared counter reads 0 the next cycle.
  - Flush does not clear the counters. The flush cycle itself counts per the pre-flush state.
- Payload is opaque: no field decode, no width conversion. in_data/out_data are bit-identical.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] pstate_t {EMPTY, FULL, SKID}.
  - Occupancy constants.
- Natural sub-module: pipe_sat_cnt (parametrised CNT_W; inputs inc, clr; async active-low reset, CLK/nRST). Instanced twice, for stall_cnt and bubble_cnt.
- Per-stage payload structs (e.g. decode->execute) stay in cpu_types_pkg and are cast to DATA_W at instantiation.

Test Plan:
- Reset, then en=1, in_valid=1, in_data=0xA5, out_ready=1 continuously -> out_valid rises 1 cycle later with out_data=0xA5, occ=1. Streaming 0x01..0x10 emerges in order, one per cycle, with no bubbles.
- Skid: FULL with 0x11, out_ready=0, accept 0x22 -> occ=2, in_ready=0. Then out_ready=1 -> 0x11 then 0x22 on consecutive cycles, in_ready returns 1 after the first drain.
- Freeze: occ=2, en=0 for 5 cycles with out_ready=1 and in_valid=1 -> no state change, occ stays 2, stall_cnt and bubble_cnt unchanged.
- Flush in SKID with in_valid=1 and en=0 -> next cycle occ=0, out_valid=0, out_data=0 (CLEAR_ON_FLUSH=1), and the input is not captured.
- Counters, CNT_W=4: 20 cycles out_valid & !out_ready -> stall_cnt=15 (saturated). Then cnt_clr pulse -> stall_cnt=0 next cycle; 3 empty en cycles -> bubble_cnt=3.
- Async reset asserted mid-stream with occ=2 -> outputs take reset values immediately (before next CLK edge); after release, in_ready=1.
